// File: rtl/tilelink_ul_responder.sv
// TileLink-UL responder backed by a flop-array memory; Get/Put bursts, denied errors.
// Define TILELINK_UL_RESPONDER_PUTPARTIAL_EN to accept PutPartialData writes.
module tilelink_ul_responder #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            RS        = 4,
  parameter logic [AW-1:0] BASE      = '0,
  parameter int            LGDEPTH   = 10,
  parameter int            LGMAXSIZE = 6
) (
  input  logic            tilelink_clock,
  input  logic            tilelink_reset,
  input  logic [2:0]      a_opcode,
  input  logic [2:0]      a_param,
  input  logic [3:0]      a_size,
  input  logic [RS-1:0]   a_source,
  input  logic [AW-1:0]   a_address,
  input  logic [DW/8-1:0] a_mask,
  input  logic [DW-1:0]   a_data,
  input  logic            a_corrupt,
  input  logic            a_valid,
  output logic            a_ready,
  output logic [2:0]      d_opcode,
  output logic [1:0]      d_param,
  output logic [3:0]      d_size,
  output logic [RS-1:0]   d_source,
  output logic            d_denied,
  output logic [DW-1:0]   d_data,
  output logic            d_corrupt,
  output logic            d_valid,
  input  logic            d_ready
);

  localparam int         SHIFT  = $clog2(DW/8);
  localparam int         DEPTH  = 1 << LGDEPTH;
  localparam logic [3:0] SHIFT4 = 4'(SHIFT);
  localparam logic [3:0] MAXSZ  = 4'(LGMAXSIZE);
`ifdef TILELINK_UL_RESPONDER_PUTPARTIAL_EN
  localparam bit PP_EN = 1'b1;
`else
  localparam bit PP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PUT_BURST,
    GET_BURST
  } state_t;

  state_t state;

  logic [DW-1:0]      mem [DEPTH];
  logic [LGDEPTH-1:0] idx;
  logic [LGDEPTH-1:0] a_idx;
  logic [LGDEPTH-1:0] rd_idx;
  logic [LGDEPTH-1:0] wr_idx;
  logic [15:0]        cnt;
  logic [15:0]        beats_m1;
  logic [AW-1:0]      off;
  logic [DW-1:0]      rd_data;
  logic               in_range;
  logic               ok;
  logic               acc;
  logic               we;
  logic               is_get;
  logic               is_putp;
  logic               is_put;
  logic               is_hint;
  logic               is_bad;
  logic               put_den;
  logic [2:0]         rsp_op;
  logic               rsp_den;
  logic               rsp_cor;
  logic               unused_param;

  assign unused_param = ^a_param;
  assign d_param      = 2'b00;

  assign off      = a_address - BASE;
  assign in_range = (a_address >= BASE) &&
                    ((off >> (LGDEPTH + SHIFT)) == '0);
  assign ok       = in_range && (a_size <= MAXSZ);
  assign a_idx    = off[SHIFT +: LGDEPTH];
  assign beats_m1 = (a_size > SHIFT4) ?
                    ((16'd1 << (a_size - SHIFT4)) - 16'd1) :
                    16'd0;

  assign is_get  = (a_opcode == 3'd4);
  assign is_putp = (a_opcode == 3'd1);
  assign is_put  = (a_opcode == 3'd0) || is_putp;
  assign is_hint = (a_opcode == 3'd5);
  assign is_bad  = (a_opcode == 3'd2) || (a_opcode == 3'd3);
  // PutPartial without the feature is consumed like a Put but never writes
  assign put_den = !ok || (is_putp && !PP_EN);

  always_comb begin
    a_ready = 1'b0;
    unique case (state)
      IDLE:      a_ready = !d_valid || d_ready;
      PUT_BURST: a_ready = 1'b1;
      GET_BURST: a_ready = 1'b0;
      default:   a_ready = 1'b0;
    endcase
  end

  assign acc     = a_valid && a_ready;
  assign wr_idx  = (state == PUT_BURST) ? idx : a_idx;
  assign rd_idx  = (state == GET_BURST) ? idx : a_idx;
  assign rd_data = mem[rd_idx];

  always_comb begin
    we = 1'b0;
    if (acc && !a_corrupt && !tilelink_reset) begin
      if (state == IDLE) begin
        we = is_put && !put_den;
      end else if (state == PUT_BURST) begin
        we = !rsp_den;
      end
    end
  end

  always_ff @(posedge tilelink_clock) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (a_mask[i]) begin
          mem[wr_idx][8*i +: 8] <= a_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge tilelink_clock) begin
    if (tilelink_reset) begin
      state     <= IDLE;
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 4'd0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= '0;
      d_corrupt <= 1'b0;
      idx       <= '0;
      cnt       <= 16'd0;
      rsp_op    <= 3'd0;
      rsp_den   <= 1'b0;
      rsp_cor   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_valid && d_ready) begin
            d_valid <= 1'b0;
          end
          if (acc) begin
            d_size    <= a_size;
            d_source  <= a_source;
            d_data    <= '0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
            d_opcode  <= 3'd0;
            idx       <= a_idx + LGDEPTH'(1);
            cnt       <= beats_m1;
            unique case (1'b1)
              is_get: begin
                d_valid   <= 1'b1;
                d_opcode  <= 3'd1;
                d_denied  <= !ok;
                d_corrupt <= !ok;
                d_data    <= ok ? rd_data : '0;
                rsp_den   <= !ok;
                if (beats_m1 != 16'd0) begin
                  state <= GET_BURST;
                end
              end
              is_put, is_bad: begin
                rsp_op  <= is_bad ? 3'd1 : 3'd0;
                rsp_den <= is_bad || put_den;
                rsp_cor <= is_bad;
                if (beats_m1 == 16'd0) begin
                  d_valid   <= 1'b1;
                  d_opcode  <= is_bad ? 3'd1 : 3'd0;
                  d_denied  <= is_bad || put_den;
                  d_corrupt <= is_bad;
                end else begin
                  d_valid <= 1'b0;
                  state   <= PUT_BURST;
                end
              end
              is_hint: begin
                d_valid  <= 1'b1;
                d_opcode <= 3'd2;
              end
              default: begin
                d_valid  <= 1'b1;
                d_denied <= 1'b1;
              end
            endcase
          end
        end
        PUT_BURST: begin
          if (a_valid) begin
            idx <= idx + LGDEPTH'(1);
            cnt <= cnt - 16'd1;
            // d_size/d_source still hold the first beat's values
            if (cnt == 16'd1) begin
              d_valid   <= 1'b1;
              d_opcode  <= rsp_op;
              d_denied  <= rsp_den;
              d_corrupt <= rsp_cor;
              d_data    <= '0;
              state     <= IDLE;
            end
          end
        end
        GET_BURST: begin
          if (d_ready) begin
            if (cnt == 16'd0) begin
              d_valid <= 1'b0;
              state   <= IDLE;
            end else begin
              d_data <= rsp_den ? '0 : rd_data;
              idx    <= idx + LGDEPTH'(1);
              cnt    <= cnt - 16'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          d_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tilelink_ul_responder.sv
// Scoreboard bench for tilelink_ul_responder: directed A requests, D monitor.
// Honours TILELINK_UL_RESPONDER_PUTPARTIAL_EN for PutPartial expectations.
module tb_tilelink_ul_responder;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  size;
    logic [3:0]  src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [3:0]  a_size = '0;
  logic [3:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_corrupt = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  logic        d_valid;
  logic        d_ready = 1'b1;

  int   errors = 0;
  int   checks = 0;
  rsp_t q[$];
  rsp_t held;
  bit   stalled = 0;

  tilelink_ul_responder dut (
    .tilelink_clock (clk),
    .tilelink_reset (rst),
    .a_opcode       (a_opcode),
    .a_param        (a_param),
    .a_size         (a_size),
    .a_source       (a_source),
    .a_address      (a_address),
    .a_mask         (a_mask),
    .a_data         (a_data),
    .a_corrupt      (a_corrupt),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .d_opcode       (d_opcode),
    .d_param        (d_param),
    .d_size         (d_size),
    .d_source       (d_source),
    .d_denied       (d_denied),
    .d_data         (d_data),
    .d_corrupt      (d_corrupt),
    .d_valid        (d_valid),
    .d_ready        (d_ready)
  );

  always #5 clk = ~clk;

  function automatic rsp_t cur_rsp();
    rsp_t r;
    r.op   = d_opcode;
    r.size = d_size;
    r.src  = d_source;
    r.den  = d_denied;
    r.cor  = d_corrupt;
    r.data = d_data;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_rsp(input logic [2:0] op, input logic [3:0] size,
                            input logic [3:0] src, input logic den,
                            input logic cor, input logic [31:0] data);
    rsp_t r;
    r.op   = op;
    r.size = size;
    r.src  = src;
    r.den  = den;
    r.cor  = cor;
    r.data = data;
    q.push_back(r);
  endtask

  // drives one A beat from posedge+1 and returns at posedge+1 after acceptance
  task automatic beat(input logic [2:0] op, input logic [3:0] size,
                      input logic [3:0] src, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data,
                      input logic cor);
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = cor;
    a_valid   = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (a_ready) begin
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL a_accept_timeout op=%0d addr=%h", op, addr);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left=%0d", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: pops one expectation per D handshake, checks stall stability
  initial begin
    rsp_t g;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else if (d_valid && d_ready) begin
        g = cur_rsp();
        stalled = 0;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp got=%h", g);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL rsp got op=%0d sz=%0d src=%0d den=%0d cor=%0d data=%h exp op=%0d sz=%0d src=%0d den=%0d cor=%0d data=%h",
                     g.op, g.size, g.src, g.den, g.cor, g.data,
                     e.op, e.size, e.src, e.den, e.cor, e.data);
          end
        end
      end else if (d_valid) begin
        g = cur_rsp();
        if (stalled) begin
          checks++;
          if (g !== held) begin
            errors++;
            $display("FAIL stall_stable got=%h exp=%h", g, held);
          end
        end
        held    = g;
        stalled = 1;
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] pp_word;
    logic        pp_den;
`ifdef TILELINK_UL_RESPONDER_PUTPARTIAL_EN
    pp_word = 32'h00BB00DD;
    pp_den  = 1'b0;
`else
    pp_word = 32'h0000_0000;
    pp_den  = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_opcode", 32'(d_opcode), 32'd0);
    chk("rst_d_data", d_data, 32'd0);
    chk("rst_d_flags", {28'd0, d_denied, d_corrupt, d_param}, 32'd0);
    chk("rst_d_size_src", {24'd0, d_size, d_source}, 32'd0);

    // single-beat Put then Get at 0x10
    expect_rsp(3'd0, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0);
    beat(3'd0, 4'd2, 4'd3, 32'h10, 4'hF, 32'hCAFEF00D, 1'b0);
    chk("put_latency", 32'(d_valid), 32'd1);
    expect_rsp(3'd1, 4'd2, 4'd3, 1'b0, 1'b0, 32'hCAFEF00D);
    beat(3'd4, 4'd2, 4'd3, 32'h10, 4'hF, 32'h0, 1'b0);
    chk("get_latency", 32'(d_valid), 32'd1);
    drain();

    // 4-beat Put burst followed immediately by a 4-beat Get
    expect_rsp(3'd0, 4'd4, 4'd5, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      beat(3'd0, 4'd4, 4'd5, 32'h20, 4'hF, 32'h11111111 * i, 1'b0);
      if (i < 4) chk("put_burst_no_d", 32'(d_valid), 32'd0);
    end
    for (int i = 1; i <= 4; i++) begin
      expect_rsp(3'd1, 4'd4, 4'd6, 1'b0, 1'b0, 32'h11111111 * i);
    end
    beat(3'd4, 4'd4, 4'd6, 32'h20, 4'hF, 32'h0, 1'b0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (d_valid) chk("get_burst_aready", 32'(a_ready), 32'd0);
      if (q.size() == 0) break;
    end
    drain();

    // 2-beat Get with back-pressure
    expect_rsp(3'd1, 4'd3, 4'd7, 1'b0, 1'b0, 32'h11111111);
    expect_rsp(3'd1, 4'd3, 4'd7, 1'b0, 1'b0, 32'h22222222);
    beat(3'd4, 4'd3, 4'd7, 32'h20, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      d_ready = pat[i % 4];
      @(posedge clk);
      #1;
    end
    d_ready = 1'b1;
    drain();
    chk("idle_after_stall", 32'(a_ready), 32'd1);

    // out-of-range boundary and neighbour integrity
    expect_rsp(3'd0, 4'd2, 4'd1, 1'b0, 1'b0, 32'h0);
    beat(3'd0, 4'd2, 4'd1, 32'hFFC, 4'hF, 32'h5A5A5A5A, 1'b0);
    expect_rsp(3'd0, 4'd2, 4'd1, 1'b0, 1'b0, 32'h0);
    beat(3'd0, 4'd2, 4'd1, 32'h0, 4'hF, 32'h0, 1'b0);
    expect_rsp(3'd1, 4'd2, 4'd1, 1'b1, 1'b1, 32'h0);
    beat(3'd4, 4'd2, 4'd1, 32'h1000, 4'hF, 32'h0, 1'b0);
    expect_rsp(3'd0, 4'd2, 4'd1, 1'b1, 1'b0, 32'h0);
    beat(3'd0, 4'd2, 4'd1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b0);
    expect_rsp(3'd1, 4'd2, 4'd1, 1'b0, 1'b0, 32'h5A5A5A5A);
    beat(3'd4, 4'd2, 4'd1, 32'hFFC, 4'hF, 32'h0, 1'b0);
    expect_rsp(3'd1, 4'd2, 4'd1, 1'b0, 1'b0, 32'h0);
    beat(3'd4, 4'd2, 4'd1, 32'h0, 4'hF, 32'h0, 1'b0);
    drain();

    // PutPartialData on a zero word
    expect_rsp(3'd0, 4'd2, 4'd2, pp_den, 1'b0, 32'h0);
    beat(3'd1, 4'd2, 4'd2, 32'h0, 4'b0101, 32'hAABBCCDD, 1'b0);
    expect_rsp(3'd1, 4'd2, 4'd2, 1'b0, 1'b0, pp_word);
    beat(3'd4, 4'd2, 4'd2, 32'h0, 4'hF, 32'h0, 1'b0);
    drain();

    // corrupt beat must not write
    expect_rsp(3'd0, 4'd2, 4'd2, 1'b0, 1'b0, 32'h0);
    beat(3'd0, 4'd2, 4'd2, 32'h10, 4'hF, 32'h0BADBAD0, 1'b1);
    expect_rsp(3'd1, 4'd2, 4'd2, 1'b0, 1'b0, 32'hCAFEF00D);
    beat(3'd4, 4'd2, 4'd2, 32'h10, 4'hF, 32'h0, 1'b0);

    // Hint, reserved and unsupported opcodes
    expect_rsp(3'd2, 4'd2, 4'd4, 1'b0, 1'b0, 32'h0);
    beat(3'd5, 4'd2, 4'd4, 32'h0, 4'hF, 32'h0, 1'b0);
    expect_rsp(3'd0, 4'd2, 4'd4, 1'b1, 1'b0, 32'h0);
    beat(3'd6, 4'd2, 4'd4, 32'h0, 4'hF, 32'h0, 1'b0);
    expect_rsp(3'd1, 4'd2, 4'd4, 1'b1, 1'b1, 32'h0);
    beat(3'd2, 4'd2, 4'd4, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b0);
    expect_rsp(3'd1, 4'd3, 4'd4, 1'b1, 1'b1, 32'h0);
    beat(3'd3, 4'd3, 4'd4, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b0);
    beat(3'd3, 4'd3, 4'd4, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b0);
    expect_rsp(3'd1, 4'd3, 4'd4, 1'b0, 1'b0, 32'h11111111);
    expect_rsp(3'd1, 4'd3, 4'd4, 1'b0, 1'b0, 32'h22222222);
    beat(3'd4, 4'd3, 4'd4, 32'h20, 4'hF, 32'h0, 1'b0);
    drain();

    // oversize Get: 32 denied beats
    for (int i = 0; i < 32; i++) begin
      expect_rsp(3'd1, 4'd7, 4'd9, 1'b1, 1'b1, 32'h0);
    end
    beat(3'd4, 4'd7, 4'd9, 32'h0, 4'hF, 32'h0, 1'b0);
    drain();

    // reset during a 4-beat Get after the first beat
    expect_rsp(3'd1, 4'd4, 4'd8, 1'b0, 1'b0, 32'h11111111);
    for (int i = 2; i <= 4; i++) begin
      expect_rsp(3'd1, 4'd4, 4'd8, 1'b0, 1'b0, 32'h11111111 * i);
    end
    beat(3'd4, 4'd4, 4'd8, 32'h20, 4'hF, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_first_done", 32'(q.size()), 32'd3);
    rst     = 1'b1;
    d_ready = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_d_valid", 32'(d_valid), 32'd0);
    rst     = 1'b0;
    d_ready = 1'b1;
    chk("mid_rst_idle", 32'(a_ready), 32'd1);
    expect_rsp(3'd1, 4'd2, 4'd8, 1'b0, 1'b0, 32'h22222222);
    beat(3'd4, 4'd2, 4'd8, 32'h24, 4'hF, 32'h0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
